// File: rtl/mem_responder.sv
// Memory-side responder for the CPU control FSM bus.
// Services one read or write against an internal word array after
// WAIT_CYCLES wait states, then pulses o_ack for one cycle. A side loader
// port writes the array directly while the responder is idle.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ack,
    output logic              o_busy,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              busy_q;

    logic              accept_d;
    logic              ld_write_d;
    logic              enter_ack_d;
    logic [ADDR_W-1:0] acc_addr_d;
    logic              acc_rw_d;
    logic [DATA_W-1:0] acc_wdata_d;

    // Decode request acceptance and the access performed on the ACK-entry edge.
    // With zero wait states the access uses the bus values being latched on
    // that same edge; otherwise it uses the latched copies.
    always_comb begin
        ld_write_d  = (state_q == S_IDLE) && i_ld_en;
        accept_d    = (state_q == S_IDLE) && i_req && !i_ld_en;
        enter_ack_d = (accept_d && ZERO_WAIT) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd1));
        if (state_q == S_IDLE) begin
            acc_addr_d  = i_addr;
            acc_rw_d    = i_rw;
            acc_wdata_d = i_wdata;
        end else begin
            acc_addr_d  = addr_q;
            acc_rw_d    = rw_q;
            acc_wdata_d = wdata_q;
        end
    end

    // Transaction FSM with registered ack, busy and read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        addr_q  <= i_addr;
                        rw_q    <= i_rw;
                        wdata_q <= i_wdata;
                        cnt_q   <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ZERO_WAIT ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (enter_ack_d) begin
                ack_q <= 1'b1;
                if (!acc_rw_d) begin
                    rdata_q <= mem[acc_addr_d];
                end
            end
        end
    end

    // Array writes: committed access on ACK entry, or loader write in IDLE.
    // Reset suppresses both so an interrupted write never lands.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (enter_ack_d && acc_rw_d) begin
                mem[acc_addr_d] <= acc_wdata_d;
            end else if (ld_write_d) begin
                mem[i_ld_addr] <= i_ld_data;
            end
        end
    end

    assign o_rdata = rdata_q;
    assign o_ack   = ack_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (0, 1 and 3 wait states)
// share one stimulus bus; most checks target the default instance.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    logic [7:0] rdata0, rdata1, rdata3;
    logic       ack0, ack1, ack3;
    logic       busy0, busy1, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_rw(rw), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata0), .o_ack(ack0), .o_busy(busy0),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_rw(rw), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata1), .o_ack(ack1), .o_busy(busy1),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_rw(rw), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata3), .o_ack(ack3), .o_busy(busy3),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy0 || busy1 || busy3) && n < 50) begin
            tick();
            n++;
        end
        check_val(tag, 32'(busy0 || busy1 || busy3), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bit seen;
        req = 1'b1; rw = 1'b0; addr = a;
        tick();
        req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ack1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_val({tag, "_ack"}, 32'(seen), 32'd1);
        check_val({tag, "_data"}, 32'(rdata1), 32'(exp));
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        check_val("rst_ack", 32'(ack1), 32'd0);
        check_val("rst_busy", 32'(busy1), 32'd0);
        check_val("rst_rdata", 32'(rdata1), 32'd0);
        rst = 1'b0;
        tick();

        // Basic read and latency across the three wait-state settings.
        load(8'h10, 8'hA5);
        req = 1'b1; rw = 1'b0; addr = 8'h10;          // cycle 0
        tick();                                         // cycle 1
        req = 1'b0;
        check_val("lat1_c1_busy", 32'(busy1), 32'd1);
        check_val("lat1_c1_ack", 32'(ack1), 32'd0);
        check_val("lat0_c1_ack", 32'(ack0), 32'd1);
        check_val("lat0_c1_data", 32'(rdata0), 32'hA5);
        tick();                                         // cycle 2
        check_val("lat1_c2_busy", 32'(busy1), 32'd1);
        check_val("lat1_c2_ack", 32'(ack1), 32'd1);
        check_val("lat1_c2_data", 32'(rdata1), 32'hA5);
        check_val("lat0_c2_ack", 32'(ack0), 32'd0);
        check_val("lat3_c2_ack", 32'(ack3), 32'd0);
        tick();                                         // cycle 3
        check_val("lat1_c3_busy", 32'(busy1), 32'd0);
        check_val("lat1_c3_ack", 32'(ack1), 32'd0);
        check_val("lat1_c3_hold", 32'(rdata1), 32'hA5);
        check_val("lat3_c3_ack", 32'(ack3), 32'd0);
        tick();                                         // cycle 4
        check_val("lat3_c4_ack", 32'(ack3), 32'd1);
        check_val("lat3_c4_data", 32'(rdata3), 32'hA5);
        tick();
        check_val("lat3_c5_ack", 32'(ack3), 32'd0);
        wait_idle("lat_idle");

        // Write then read with the request held throughout.
        req = 1'b1; rw = 1'b1; addr = 8'h20; wdata = 8'h3C;   // cycle 0
        tick();                                                // cycle 1
        rw = 1'b0;
        check_val("wr_c1_ack", 32'(ack1), 32'd0);
        tick();                                                // cycle 2
        check_val("wr_c2_ack", 32'(ack1), 32'd1);
        check_val("wr_c2_rdata", 32'(rdata1), 32'hA5);
        tick();                                                // cycle 3
        check_val("gap_busy", 32'(busy1), 32'd0);
        check_val("gap_ack", 32'(ack1), 32'd0);
        tick();                                                // cycle 4
        req = 1'b0;
        check_val("rd_c4_busy", 32'(busy1), 32'd1);
        check_val("rd_c4_ack", 32'(ack1), 32'd0);
        tick();                                                // cycle 5
        check_val("rd_c5_ack", 32'(ack1), 32'd1);
        check_val("rd_c5_data", 32'(rdata1), 32'h3C);
        tick();
        check_val("rd_c6_ack", 32'(ack1), 32'd0);
        wait_idle("rw_idle");

        // Bus and loader activity during WAIT is ignored.
        load(8'h41, 8'h55);
        load(8'h42, 8'h66);
        req = 1'b1; rw = 1'b1; addr = 8'h40; wdata = 8'h77;   // cycle 0
        tick();                                                // cycle 1 (WAIT)
        req = 1'b0; addr = 8'h41; wdata = 8'hFF;
        ld_en = 1'b1; ld_addr = 8'h42; ld_data = 8'hEE;
        tick();                                                // cycle 2 (ACK)
        ld_en = 1'b0;
        check_val("ign_ack", 32'(ack1), 32'd1);
        wait_idle("ign_idle");
        do_read("ign_m40", 8'h40, 8'h77);
        do_read("ign_m41", 8'h41, 8'h55);
        do_read("ign_m42", 8'h42, 8'h66);

        // Reset during WAIT discards the pending write.
        load(8'h30, 8'h11);
        req = 1'b1; rw = 1'b1; addr = 8'h30; wdata = 8'h99;   // cycle 0
        tick();                                                // cycle 1 (WAIT)
        req = 1'b0; rst = 1'b1;
        tick();
        check_val("mrst_ack", 32'(ack1), 32'd0);
        check_val("mrst_busy", 32'(busy1), 32'd0);
        check_val("mrst_rdata", 32'(rdata1), 32'd0);
        rst = 1'b0;
        tick();
        check_val("mrst_ack2", 32'(ack1), 32'd0);
        check_val("mrst_busy2", 32'(busy1), 32'd0);
        do_read("mrst_m30", 8'h30, 8'h11);

        // Loader and request in the same IDLE cycle: load first, request deferred.
        ld_en = 1'b1; ld_addr = 8'h50; ld_data = 8'hC3;
        req = 1'b1; rw = 1'b0; addr = 8'h50;                   // cycle 0
        tick();                                                 // cycle 1
        ld_en = 1'b0;
        check_val("pri_c1_busy", 32'(busy1), 32'd0);
        tick();                                                 // cycle 2
        req = 1'b0;
        check_val("pri_c2_busy", 32'(busy1), 32'd1);
        check_val("pri_c2_ack", 32'(ack1), 32'd0);
        tick();                                                 // cycle 3
        check_val("pri_c3_ack", 32'(ack1), 32'd1);
        check_val("pri_c3_data", 32'(rdata1), 32'hC3);
        wait_idle("pri_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
